mem_port_arbiter: RTL and testbench

- Sequences the single shared, fixed-latency memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline.
- Grants one requester at a time, with fixed priority data > fetch.
- Holds the memory command stable for LAT cycles, then returns read data with a one-cycle ack.
- Drives the fetch and data stall signals consumed by the hazard logic.
- Discards in-flight fetches killed by if_flush from the branch resolution in decode.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one fixed-latency memory between the fetch stage (instruction
//   reads) and the memory stage (data loads/stores). Fixed priority
//   data > fetch. A granted command is held on mem_* for LAT cycles, the read
//   data is captured on the last hold cycle, and a one-cycle ack follows in
//   RESP. Unaligned accesses skip the memory and go straight to RESP with err.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   if_req/addr/flush   fetch request, byte address, kill of current fetch
//   if_ack/rdata/err    fetch response (rdata/err valid with ack)
//   if_stall            fetch stage hold
//   dm_req/wr/addr/wdata  data request (wr=1 store)
//   dm_ack/rdata/err    data response
//   dm_stall            memory stage hold
//   mem_en/wr/addr/wdata  registered memory command
//   mem_rdata           memory read data, valid on the last hold cycle
module mem_port_arbiter #(
    parameter int LAT   = 4,
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        if_flush,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    output logic        if_err,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_ack,
    output logic [15:0] dm_rdata,
    output logic        dm_err,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             owner_dm;   // 1 = data owns the current transaction
    logic             flushed;    // fetch owner was killed; drop its response
    logic             err_q;      // current transaction was unaligned
    logic             grant_dm, grant_if, grant;
    logic [15:0]      grant_addr;
    logic             unaligned;
    logic             last_hold;
    logic             in_resp;

    assign grant      = grant_dm | grant_if;
    assign grant_addr = dm_req ? dm_addr : if_addr;
    assign unaligned  = grant_addr[0];
    assign last_hold  = (state == FETCH || state == DATA) && (cnt == '0);
    assign in_resp    = (state == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                // A fetch flushed in the same cycle it is presented is never granted.
                if (dm_req)                 grant_dm = 1'b1;
                else if (if_req && !if_flush) grant_if = 1'b1;
                if (grant_dm || grant_if)
                    state_nxt = unaligned ? RESP : (grant_dm ? DATA : FETCH);
            end
            FETCH, DATA: if (cnt == '0) state_nxt = RESP;
            RESP:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Response outputs exist only in RESP; a flush arriving in RESP still
    // suppresses the fetch ack.
    assign if_ack   = in_resp & ~owner_dm & ~flushed & ~if_flush;
    assign dm_ack   = in_resp & owner_dm;
    assign if_err   = if_ack & err_q;
    assign dm_err   = dm_ack & err_q;
    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            owner_dm  <= 1'b0;
            flushed   <= 1'b0;
            err_q     <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_dm <= grant_dm;
                        flushed  <= 1'b0;
                        err_q    <= unaligned;
                        if (!unaligned) begin
                            mem_en    <= 1'b1;
                            mem_wr    <= grant_dm & dm_wr;
                            mem_addr  <= grant_addr;
                            if (grant_dm) mem_wdata <= dm_wdata;
                            cnt       <= CNT_W'(LAT - 1);
                        end
                    end
                end
                FETCH, DATA: begin
                    if (if_flush && !owner_dm) flushed <= 1'b1;
                    if (last_hold) begin
                        mem_en <= 1'b0;
                        mem_wr <= 1'b0;
                        if (!mem_wr) begin
                            if (owner_dm)                  dm_rdata <= mem_rdata;
                            else if (!flushed && !if_flush) if_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (if_flush && !owner_dm) flushed <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int LAT   = 4;
    localparam int CNT_W = 3;
    localparam int T     = LAT + 2;   // request-to-ack cycles for a memory access

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 0, if_flush = 0, dm_req = 0, dm_wr = 0;
    logic [15:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
    logic        if_ack, if_err, if_stall, dm_ack, dm_err, dm_stall;
    logic [15:0] if_rdata, dm_rdata;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] if_model = 0, dm_model = 0;   // expected rdata register contents

    mem_port_arbiter #(.LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge, outputs are observed at the falling edge.
    task automatic cyc_begin();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_end();
        @(negedge clk);
    endtask

    function automatic logic [6:0] obs_vec();
        return {mem_en, if_ack, dm_ack, if_err, dm_err, if_stall, dm_stall};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_tests++;
        if ({obs_vec(), mem_wr, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %h want 0", {obs_vec(), mem_wr, mem_addr, mem_wdata});
        end
        n_tests++;
        if ({if_rdata, dm_rdata} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata got %h want 0", {if_rdata, dm_rdata});
        end
        @(negedge clk);
        rst = 1'b1;
        if_model = 0;
        dm_model = 0;
    endtask

    task automatic test_fetch();
        logic [6:0] exp;
        for (int c = 1; c <= T + 1; c++) begin
            cyc_begin();
            if_req    = (c <= T);
            if_addr   = 16'h0010;
            mem_rdata = (c == T - 1) ? 16'hC0DE : 16'($urandom);
            cyc_end();
            exp = {c >= 2 && c <= T - 1, c == T, 1'b0, 1'b0, 1'b0, c < T, 1'b0};
            n_tests++;
            if (obs_vec() !== exp) begin
                n_fail++;
                $display("FAIL fetch_ctrl cycle %0d got %b want %b", c, obs_vec(), exp);
            end
            if (mem_en) begin
                n_tests++;
                if ({mem_wr, mem_addr} !== {1'b0, 16'h0010}) begin
                    n_fail++;
                    $display("FAIL fetch_cmd cycle %0d got %h want 00010", c, {mem_wr, mem_addr});
                end
            end
            if (c == T) begin
                n_tests++;
                if (if_rdata !== 16'hC0DE) begin
                    n_fail++;
                    $display("FAIL fetch_rdata got %h want c0de", if_rdata);
                end
            end
        end
        if_model = 16'hC0DE;
    endtask

    task automatic test_contention();
        logic [6:0]  exp;
        logic [15:0] d_val, f_val, exp_addr;
        d_val = 16'($urandom);
        f_val = 16'($urandom);
        for (int c = 1; c <= 2 * T + 1; c++) begin
            cyc_begin();
            dm_req    = (c <= T);
            dm_wr     = 1'b0;
            dm_addr   = 16'h0100;
            if_req    = (c <= 2 * T);
            if_addr   = 16'h0020;
            mem_rdata = (c == T - 1) ? d_val : (c == 2 * T - 1) ? f_val : 16'($urandom);
            cyc_end();
            exp = {(c >= 2 && c <= T - 1) || (c >= T + 2 && c <= 2 * T - 1),
                   c == 2 * T, c == T, 1'b0, 1'b0, c < 2 * T, c < T};
            n_tests++;
            if (obs_vec() !== exp) begin
                n_fail++;
                $display("FAIL contention_ctrl cycle %0d got %b want %b", c, obs_vec(), exp);
            end
            if (mem_en) begin
                exp_addr = (c <= T) ? 16'h0100 : 16'h0020;
                n_tests++;
                if (mem_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL contention_addr cycle %0d got %h want %h", c, mem_addr, exp_addr);
                end
            end
            if (c == T) begin
                n_tests++;
                if (dm_rdata !== d_val) begin
                    n_fail++;
                    $display("FAIL contention_drdata got %h want %h", dm_rdata, d_val);
                end
            end
            if (c == 2 * T) begin
                n_tests++;
                if (if_rdata !== f_val) begin
                    n_fail++;
                    $display("FAIL contention_irdata got %h want %h", if_rdata, f_val);
                end
            end
        end
        dm_model = d_val;
        if_model = f_val;
    endtask

    task automatic test_store();
        logic [6:0] exp;
        for (int c = 1; c <= T + 1; c++) begin
            cyc_begin();
            dm_req    = (c <= T);
            dm_wr     = 1'b1;
            dm_addr   = 16'h0042;
            dm_wdata  = 16'hBEEF;
            mem_rdata = 16'($urandom);
            cyc_end();
            exp = {c >= 2 && c <= T - 1, 1'b0, c == T, 1'b0, 1'b0, 1'b0, c < T};
            n_tests++;
            if (obs_vec() !== exp) begin
                n_fail++;
                $display("FAIL store_ctrl cycle %0d got %b want %b", c, obs_vec(), exp);
            end
            if (mem_en) begin
                n_tests++;
                if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 16'h0042, 16'hBEEF}) begin
                    n_fail++;
                    $display("FAIL store_cmd cycle %0d got %h want 10042beef", c, {mem_wr, mem_addr, mem_wdata});
                end
            end
            if (c == T) begin
                n_tests++;
                if (dm_rdata !== dm_model) begin
                    n_fail++;
                    $display("FAIL store_rdata got %h want %h", dm_rdata, dm_model);
                end
            end
        end
        dm_wr = 1'b0;
    endtask

    task automatic test_flush();
        logic [6:0] exp;
        for (int c = 1; c <= T + 2; c++) begin
            cyc_begin();
            if_req    = (c <= 3);
            if_flush  = (c == 3);
            if_addr   = 16'h0030;
            mem_rdata = 16'($urandom);
            cyc_end();
            exp = {c >= 2 && c <= T - 1, 1'b0, 1'b0, 1'b0, 1'b0, c <= 3, 1'b0};
            n_tests++;
            if (obs_vec() !== exp) begin
                n_fail++;
                $display("FAIL flush_ctrl cycle %0d got %b want %b", c, obs_vec(), exp);
            end
        end
        if_flush = 1'b0;
        n_tests++;
        if (if_rdata !== if_model) begin
            n_fail++;
            $display("FAIL flush_rdata got %h want %h", if_rdata, if_model);
        end
    endtask

    task automatic test_unaligned();
        logic [6:0] exp;
        for (int c = 1; c <= 4; c++) begin
            cyc_begin();
            dm_req    = (c <= 2);
            dm_wr     = 1'b0;
            dm_addr   = 16'h0003;
            mem_rdata = 16'($urandom);
            cyc_end();
            exp = {1'b0, 1'b0, c == 2, 1'b0, c == 2, 1'b0, c == 1};
            n_tests++;
            if (obs_vec() !== exp) begin
                n_fail++;
                $display("FAIL unaligned_ctrl cycle %0d got %b want %b", c, obs_vec(), exp);
            end
        end
        n_tests++;
        if (dm_rdata !== dm_model) begin
            n_fail++;
            $display("FAIL unaligned_rdata got %h want %h", dm_rdata, dm_model);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0]  exp;
        logic [15:0] val;
        for (int c = 1; c <= 2; c++) begin
            cyc_begin();
            dm_req  = 1'b1;
            dm_wr   = 1'b0;
            dm_addr = 16'h0050;
        end
        // Now in the 2nd hold cycle of the load.
        cyc_begin();
        #1;
        n_tests++;
        if (mem_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre mem_en got %b want 1", mem_en);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({mem_en, if_ack, dm_ack, if_err, dm_err, mem_wr, mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async got %h want 0",
                     {mem_en, if_ack, dm_ack, if_err, dm_err, mem_wr, mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        dm_req   = 1'b0;
        if_model = 0;
        dm_model = 0;
        @(negedge clk);
        rst = 1'b1;
        val = 16'($urandom);
        for (int c = 1; c <= T + 1; c++) begin
            cyc_begin();
            dm_req    = (c <= T);
            mem_rdata = (c == T - 1) ? val : 16'($urandom);
            cyc_end();
            exp = {c >= 2 && c <= T - 1, 1'b0, c == T, 1'b0, 1'b0, 1'b0, c < T};
            n_tests++;
            if (obs_vec() !== exp) begin
                n_fail++;
                $display("FAIL rstmid_reissue cycle %0d got %b want %b", c, obs_vec(), exp);
            end
        end
        n_tests++;
        if (dm_rdata !== val) begin
            n_fail++;
            $display("FAIL rstmid_rdata got %h want %h", dm_rdata, val);
        end
        dm_model = val;
    endtask

    // Random single-port accesses checked against the access rules:
    // aligned -> LAT hold cycles and ack at LAT+2; unaligned -> err ack at 2.
    task automatic test_random(input int n);
        logic        is_dm, wr, unal;
        logic [15:0] addr, wdata, rd;
        logic [6:0]  exp;
        int          len;
        for (int i = 0; i < n; i++) begin
            is_dm = 1'($urandom);
            wr    = is_dm & 1'($urandom);
            addr  = 16'($urandom);
            unal  = ($urandom_range(0, 5) == 0);
            addr[0] = unal;
            wdata = 16'($urandom);
            rd    = 16'($urandom);
            len   = unal ? 2 : T;
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) cyc_begin();
            for (int c = 1; c <= len + 1; c++) begin
                cyc_begin();
                dm_req    = is_dm & (c <= len);
                if_req    = !is_dm & (c <= len);
                dm_wr     = wr;
                dm_addr   = addr;
                if_addr   = addr;
                dm_wdata  = wdata;
                mem_rdata = (!unal && c == len - 1) ? rd : 16'($urandom);
                cyc_end();
                exp = {!unal && c >= 2 && c <= len - 1,
                       !is_dm && c == len, is_dm && c == len,
                       !is_dm && unal && c == len, is_dm && unal && c == len,
                       !is_dm && c < len, is_dm && c < len};
                n_tests++;
                if (obs_vec() !== exp) begin
                    n_fail++;
                    $display("FAIL rand%0d_ctrl cycle %0d got %b want %b", i, c, obs_vec(), exp);
                end
                if (mem_en) begin
                    n_tests++;
                    if ({mem_wr, mem_addr} !== {wr, addr} || (wr && mem_wdata !== wdata)) begin
                        n_fail++;
                        $display("FAIL rand%0d_cmd cycle %0d got %h want %h", i, c,
                                 {mem_wr, mem_addr, mem_wdata}, {wr, addr, wdata});
                    end
                end
                if (c == len) begin
                    if (!unal && !wr) begin
                        if (is_dm) dm_model = rd;
                        else       if_model = rd;
                    end
                    n_tests++;
                    if ({if_rdata, dm_rdata} !== {if_model, dm_model}) begin
                        n_fail++;
                        $display("FAIL rand%0d_rdata got %h want %h", i, {if_rdata, dm_rdata}, {if_model, dm_model});
                    end
                end
            end
        end
        dm_req = 1'b0;
        if_req = 1'b0;
        dm_wr  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_contention();
        test_store();
        test_flush();
        test_unaligned();
        test_reset_mid();
        test_random(30);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
